// File: rtl/stateless_alu_sched.sv
// Round-robin scheduler sharing one stateless ALU between NUM_REQ requesters.
// Issues one configured request per cycle and returns each result tagged with its requester ID.
module stateless_alu_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      i__req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [32*NUM_REQ-1:0]   i__req_pkt_1,
    input  logic [32*NUM_REQ-1:0]   i__req_pkt_2,
    input  logic [32*NUM_REQ-1:0]   i__req_pkt_3,
    input  logic                    i__cfg_we,
    input  logic [ID_W-1:0]         i__cfg_idx,
    input  logic [3:0]              i__cfg_opcode,
    input  logic [9:0]              i__cfg_sel,
    input  logic [31:0]             i__cfg_cons,
    output logic [31:0]             o_alu_pkt_1,
    output logic [31:0]             o_alu_pkt_2,
    output logic [31:0]             o_alu_pkt_3,
    output logic [31:0]             o_alu_cons_1,
    output logic [3:0]              o_alu_opcode,
    output logic [9:0]              o_alu_sel,
    input  logic [31:0]             i__alu_result,
    output logic                    o_rsp_valid,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [31:0]             o_rsp_data
);

    logic [3:0]         r_cfg_opcode [NUM_REQ];
    logic [9:0]         r_cfg_sel    [NUM_REQ];
    logic [31:0]        r_cfg_cons   [NUM_REQ];
    logic [NUM_REQ-1:0] r_cfg_valid;

    logic [ID_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    logic               w_fire;
    logic [ID_W-1:0]    w_gnt_id;
    logic [31:0]        w_pkt_1;
    logic [31:0]        w_pkt_2;
    logic [31:0]        w_pkt_3;

    logic [31:0]        r_alu_pkt_1;
    logic [31:0]        r_alu_pkt_2;
    logic [31:0]        r_alu_pkt_3;
    logic [31:0]        r_alu_cons_1;
    logic [3:0]         r_alu_opcode;
    logic [9:0]         r_alu_sel;

    logic [LATENCY:0]   r_pipe_vld;
    logic [ID_W-1:0]    r_pipe_id [LATENCY+1];

    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [31:0]        r_rsp_data;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        return ID_W'(sum % NUM_REQ);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_valid <= '0;
        end else if (i__cfg_we) begin
            r_cfg_valid[i__cfg_idx] <= 1'b1;
        end
    end

    // Data fields need no reset: cfg_valid gates every use of them.
    always_ff @(posedge clk) begin
        if (i__cfg_we) begin
            r_cfg_opcode[i__cfg_idx] <= i__cfg_opcode;
            r_cfg_sel[i__cfg_idx]    <= i__cfg_sel;
            r_cfg_cons[i__cfg_idx]   <= i__cfg_cons;
        end
    end

    always_comb begin
        w_elig   = i__req_valid & r_cfg_valid;
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_elig[wrap_add(r_ptr, i)]) begin
                w_found  = 1'b1;
                w_gnt_id = wrap_add(r_ptr, i);
            end
        end
    end

    assign w_fire      = w_found & ~rst;
    assign o_req_ready = w_fire ? (NUM_REQ'(1) << w_gnt_id) : '0;

    always_comb begin
        w_pkt_1 = '0;
        w_pkt_2 = '0;
        w_pkt_3 = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_id == ID_W'(k)) begin
                w_pkt_1 = i__req_pkt_1[32*k +: 32];
                w_pkt_2 = i__req_pkt_2[32*k +: 32];
                w_pkt_3 = i__req_pkt_3[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= wrap_add(w_gnt_id, 1);
        end
    end

    // Config read here sees the pre-edge entry, so a same-cycle write applies from the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_pkt_1  <= '0;
            r_alu_pkt_2  <= '0;
            r_alu_pkt_3  <= '0;
            r_alu_cons_1 <= '0;
            r_alu_opcode <= '0;
            r_alu_sel    <= '0;
        end else if (w_fire) begin
            r_alu_pkt_1  <= w_pkt_1;
            r_alu_pkt_2  <= w_pkt_2;
            r_alu_pkt_3  <= w_pkt_3;
            r_alu_cons_1 <= r_cfg_cons[w_gnt_id];
            r_alu_opcode <= r_cfg_opcode[w_gnt_id];
            r_alu_sel    <= r_cfg_sel[w_gnt_id];
        end
    end

    assign o_alu_pkt_1  = r_alu_pkt_1;
    assign o_alu_pkt_2  = r_alu_pkt_2;
    assign o_alu_pkt_3  = r_alu_pkt_3;
    assign o_alu_cons_1 = r_alu_cons_1;
    assign o_alu_opcode = r_alu_opcode;
    assign o_alu_sel    = r_alu_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_fire;
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pipe_id[0] <= w_gnt_id;
        for (int unsigned i = 1; i <= LATENCY; i++) begin
            r_pipe_id[i] <= r_pipe_id[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= r_pipe_vld[LATENCY];
            if (r_pipe_vld[LATENCY]) begin
                r_rsp_id   <= r_pipe_id[LATENCY];
                r_rsp_data <= i__alu_result;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_stateless_alu_sched.sv
// Directed bench for stateless_alu_sched: a 1-cycle ALU model, ready checks in the stimulus
// thread, and a scoreboard monitor matching each response pulse on id, data and arrival cycle.
module tb_stateless_alu_sched;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned LATENCY = 1;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        int              due;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_pkt_1;
    logic [32*NUM_REQ-1:0] req_pkt_2;
    logic [32*NUM_REQ-1:0] req_pkt_3;
    logic                  cfg_we;
    logic [ID_W-1:0]       cfg_idx;
    logic [3:0]            cfg_opcode;
    logic [9:0]            cfg_sel;
    logic [31:0]           cfg_cons;
    logic [31:0]           alu_pkt_1;
    logic [31:0]           alu_pkt_2;
    logic [31:0]           alu_pkt_3;
    logic [31:0]           alu_cons_1;
    logic [3:0]            alu_opcode;
    logic [9:0]            alu_sel;
    logic [31:0]           alu_result;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t mon_e;

    stateless_alu_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i__req_valid  (req_valid),
        .o_req_ready   (req_ready),
        .i__req_pkt_1  (req_pkt_1),
        .i__req_pkt_2  (req_pkt_2),
        .i__req_pkt_3  (req_pkt_3),
        .i__cfg_we     (cfg_we),
        .i__cfg_idx    (cfg_idx),
        .i__cfg_opcode (cfg_opcode),
        .i__cfg_sel    (cfg_sel),
        .i__cfg_cons   (cfg_cons),
        .o_alu_pkt_1   (alu_pkt_1),
        .o_alu_pkt_2   (alu_pkt_2),
        .o_alu_pkt_3   (alu_pkt_3),
        .o_alu_cons_1  (alu_cons_1),
        .o_alu_opcode  (alu_opcode),
        .o_alu_sel     (alu_sel),
        .i__alu_result (alu_result),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_id      (rsp_id),
        .o_rsp_data    (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: select 0=pkt_1 1=pkt_2 2=cons 3=pkt_3; op 0 add, 1 sub, 2 xor, 3 and.
    function automatic logic [31:0] operand(input logic [1:0] s, input logic [31:0] p1,
                                            input logic [31:0] p2, input logic [31:0] p3,
                                            input logic [31:0] c);
        case (s)
            2'd0:    return p1;
            2'd1:    return p2;
            2'd2:    return c;
            default: return p3;
        endcase
    endfunction

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [9:0] sel,
                                           input logic [31:0] p1, input logic [31:0] p2,
                                           input logic [31:0] p3, input logic [31:0] c);
        logic [31:0] a;
        logic [31:0] b;
        a = operand(sel[1:0], p1, p2, p3, c);
        b = operand(sel[3:2], p1, p2, p3, c);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge clk)
        alu_result <= alu_fn(alu_opcode, alu_sel, alu_pkt_1, alu_pkt_2, alu_pkt_3, alu_cons_1);

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing: no response by cycle %0d, expected id %0d data %h at cycle %0d",
                     cyc, sb[0].id, sb[0].data, sb[0].due);
            mon_e = sb.pop_front();
        end
        if (rsp_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id %0d data %h at cycle %0d, expected no response",
                         rsp_id, rsp_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (rsp_id !== mon_e.id || rsp_data !== mon_e.data || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL rsp: got id %0d data %h cycle %0d, expected id %0d data %h cycle %0d",
                             rsp_id, rsp_data, cyc, mon_e.id, mon_e.data, mon_e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ready(input string name, input logic [NUM_REQ-1:0] exp);
        #1;
        chk(name, 32'(req_ready), 32'(exp));
    endtask

    // Response for a grant in the current cycle lands three cycles later.
    task automatic push(input logic [ID_W-1:0] id, input logic [31:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.due  = cyc + 2 + LATENCY;
        sb.push_back(e);
    endtask

    task automatic set_req(input int k, input logic [31:0] p1, input logic [31:0] p2,
                           input logic [31:0] p3);
        req_pkt_1[32*k +: 32] = p1;
        req_pkt_2[32*k +: 32] = p2;
        req_pkt_3[32*k +: 32] = p3;
    endtask

    task automatic cfg_set(input logic [ID_W-1:0] idx, input logic [3:0] op,
                           input logic [9:0] sel, input logic [31:0] c);
        cfg_we     = 1'b1;
        cfg_idx    = idx;
        cfg_opcode = op;
        cfg_sel    = sel;
        cfg_cons   = c;
    endtask

    task automatic cfg_write(input logic [ID_W-1:0] idx, input logic [3:0] op,
                             input logic [9:0] sel, input logic [31:0] c);
        cfg_set(idx, op, sel, c);
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_pkt_1 = '0;
        req_pkt_2 = '0;
        req_pkt_3 = '0;
        cfg_we = 1'b0;
        cfg_idx = '0;
        cfg_opcode = '0;
        cfg_sel = '0;
        cfg_cons = '0;

        // Reset state
        req_valid = 4'b1111;
        tick();
        tick();
        chk_ready("ready_in_reset", 4'b0000);
        rst = 1'b0;
        req_valid = '0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_alu_pkt_1", alu_pkt_1, 32'd0);
        req_valid = 4'b1111;
        chk_ready("ready_unconfigured", 4'b0000);
        req_valid = '0;

        // Basic: entry 0 = add pkt_1 + cons(5), pkt_1 = 10
        cfg_write(2'd0, 4'd0, 10'h008, 32'd5);
        set_req(0, 32'd10, 32'd0, 32'd0);
        req_valid = 4'b0001;
        chk_ready("basic_grant0", 4'b0001);
        push(2'd0, 32'd15);
        tick();
        req_valid = '0;
        idle(4);

        // Unconfigured requester 2 never granted, then configured (xor pkt_1 ^ pkt_3)
        set_req(2, 32'hF0F0_0000, 32'd0, 32'h0F0F_1234);
        req_valid = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            chk_ready("unconf_ready2", 4'b0000);
            tick();
        end
        cfg_set(2'd2, 4'd2, 10'h00C, 32'd0);
        chk_ready("cfg_write_cycle_ready2", 4'b0000);
        tick();
        cfg_we = 1'b0;
        chk_ready("after_cfg_ready2", 4'b0100);
        push(2'd2, 32'hFFFF_1234);
        tick();
        req_valid = '0;
        idle(4);

        // Configure 1 (sub pkt_1 - pkt_2) and 3 (and pkt_2 & cons)
        cfg_write(2'd1, 4'd1, 10'h004, 32'd0);
        cfg_write(2'd3, 4'd3, 10'h009, 32'h0000_FFFF);
        set_req(1, 32'd100, 32'd58, 32'd0);
        set_req(3, 32'd0, 32'h1234_5678, 32'd0);
        req_valid = 4'b1000;
        chk_ready("single_grant3", 4'b1000);
        push(2'd3, 32'h0000_5678);
        tick();

        // All four valid from ptr 0: grants rotate 0,1,2,3,0,1,2,3
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0: begin chk_ready("rr_grant0", 4'b0001); push(2'd0, 32'd15); end
                1: begin chk_ready("rr_grant1", 4'b0010); push(2'd1, 32'd42); end
                2: begin chk_ready("rr_grant2", 4'b0100); push(2'd2, 32'hFFFF_1234); end
                default: begin chk_ready("rr_grant3", 4'b1000); push(2'd3, 32'h0000_5678); end
            endcase
            tick();
        end
        req_valid = '0;
        idle(5);

        // Collision: write entry 1 to add while granting 1 -> old subtract, then new add
        set_req(1, 32'd7, 32'd3, 32'd0);
        req_valid = 4'b0010;
        cfg_set(2'd1, 4'd0, 10'h004, 32'd0);
        chk_ready("collide_grant1", 4'b0010);
        push(2'd1, 32'd4);
        tick();
        cfg_we = 1'b0;
        chk_ready("post_collide_grant1", 4'b0010);
        push(2'd1, 32'd10);
        tick();
        req_valid = '0;
        idle(4);

        // ptr = 2 with 1 and 3 valid: 3 first, then 1
        set_req(1, 32'd20, 32'd22, 32'd0);
        set_req(3, 32'd0, 32'hABCD_EF01, 32'd0);
        req_valid = 4'b1010;
        chk_ready("wrap_grant3", 4'b1000);
        push(2'd3, 32'h0000_EF01);
        tick();
        chk_ready("wrap_grant1", 4'b0010);
        push(2'd1, 32'd42);
        tick();
        req_valid = '0;
        idle(5);

        // Reset the cycle after a grant: in-flight op dropped, config cleared
        req_valid = 4'b0001;
        chk_ready("pre_reset_grant0", 4'b0001);
        tick();
        rst = 1'b1;
        req_valid = 4'b1111;
        chk_ready("ready_during_reset", 4'b0000);
        tick();
        rst = 1'b0;
        chk("post_rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("post_rst_alu_cons", alu_cons_1, 32'd0);
        chk("post_rst_alu_pkt_1", alu_pkt_1, 32'd0);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk_ready("post_rst_unconfigured", 4'b0000);
            tick();
        end
        req_valid = '0;
        cfg_write(2'd0, 4'd0, 10'h008, 32'd5);
        req_valid = 4'b0001;
        chk_ready("reconfig_grant0", 4'b0001);
        push(2'd0, 32'd15);
        tick();
        req_valid = '0;
        idle(6);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
